sdf_butterfly_stage: RTL and testbench

//   Radix-2 single-path delay-feedback (SDF) butterfly stage. Consumes the
//   per-cycle control (state) and twiddle (w_r/w_i) stream from the stage

---
 rtl/sdf_butterfly_stage.sv | 96 +++++++++
 tb/tb_sdf_butterfly_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sdf_butterfly_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: fill / butterfly / twiddle per cycle.
// Optional macro BFLY_ROUND_EN: round-half-up on the twiddle product instead of floor.
module sdf_butterfly_stage #(
  parameter int DATA_W = 24,
  parameter int FRAC_W = 8,
  parameter int DELAY  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic        [1:0]        state,
  input  logic signed [DATA_W-1:0] w_r,
  input  logic signed [DATA_W-1:0] w_i,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);
  localparam int PW = 2*DATA_W + 1;
  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BFLY = 2'd1;
  localparam logic [1:0] ST_TWID = 2'd2;
`ifdef BFLY_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (FRAC_W-1);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  typedef struct packed {
    logic signed [DATA_W-1:0] r;
    logic signed [DATA_W-1:0] i;
  } cplx_t;

  cplx_t [DELAY-1:0] dl;
  cplx_t             pop, push;
  logic              adv;

  logic signed [DATA_W-1:0] a_r, a_i, sum_r, sum_i, dif_r, dif_i;
  logic signed [PW-1:0]     ar_x, ai_x, wr_x, wi_x, acc_r, acc_i;

  assign pop  = dl[DELAY-1];
  assign a_r  = pop.r;
  assign a_i  = pop.i;
  assign adv  = in_valid && (state != 2'd3);

  assign sum_r = a_r + din_r;
  assign sum_i = a_i + din_i;
  assign dif_r = a_r - din_r;
  assign dif_i = a_i - din_i;

  // Sign-extend to the full product width so the complex sum cannot overflow.
  assign ar_x  = a_r;
  assign ai_x  = a_i;
  assign wr_x  = w_r;
  assign wi_x  = w_i;
  assign acc_r = ar_x * wr_x - ai_x * wi_x + RND;
  assign acc_i = ar_x * wi_x + ai_x * wr_x + RND;

  always_comb begin
    push.r = din_r;
    push.i = din_i;
    if (state == ST_BFLY) begin
      push.r = dif_r;
      push.i = dif_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl        <= '0;
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (adv) begin
        for (int k = DELAY-1; k > 0; k--) dl[k] <= dl[k-1];
        dl[0] <= push;
        case (state)
          ST_BFLY: begin
            out_valid <= 1'b1;
            dout_r    <= sum_r;
            dout_i    <= sum_i;
          end
          ST_TWID: begin
            out_valid <= 1'b1;
            dout_r    <= DATA_W'(acc_r >>> FRAC_W);
            dout_i    <= DATA_W'(acc_i >>> FRAC_W);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sdf_butterfly_stage.sv
// Directed table-driven bench for sdf_butterfly_stage (DATA_W=24, FRAC_W=8, DELAY=2).
module tb_sdf_butterfly_stage;
  localparam int DW = 24;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
  logic        [1:0]    state = 2'd0;
  logic                 out_valid;
  logic signed [DW-1:0] dout_r, dout_i;

  int checks = 0;
  int errors = 0;

  sdf_butterfly_stage #(.DATA_W(DW), .FRAC_W(8), .DELAY(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
    .state(state), .w_r(w_r), .w_i(w_i),
    .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i)
  );

  always #5 clk = ~clk;

`ifdef BFLY_ROUND_EN
  localparam int R_POS = 2;
  localparam int R_NEG = -1;
`else
  localparam int R_POS = 1;
  localparam int R_NEG = -2;
`endif

  typedef struct {
    logic       vl;
    logic [1:0] st;
    int         dr, di, wr, wi;
    logic       ev, cd;
    int         er, ei;
  } vec_t;

  vec_t blk[$];
  vec_t tv[$];

  function automatic vec_t v(logic vl, logic [1:0] st, int dr, int di, int wr, int wi,
                             logic ev, logic cd, int er, int ei);
    vec_t t;
    t.vl = vl; t.st = st; t.dr = dr; t.di = di; t.wr = wr; t.wi = wi;
    t.ev = ev; t.cd = cd; t.er = er; t.ei = ei;
    return t;
  endfunction

  task automatic chk(string nm, int idx, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t t, string nm, int idx);
    @(negedge clk);
    in_valid = t.vl; state = t.st;
    din_r = t.dr[DW-1:0]; din_i = t.di[DW-1:0];
    w_r = t.wr[DW-1:0];   w_i = t.wi[DW-1:0];
    @(posedge clk);
    #1;
    chk({nm, ".valid"}, idx, int'(out_valid), int'(t.ev));
    if (t.cd) begin
      chk({nm, ".dout_r"}, idx, int'(dout_r), t.er);
      chk({nm, ".dout_i"}, idx, int'(dout_i), t.ei);
    end
  endtask

  task automatic check_zero(string nm, int idx);
    chk({nm, ".valid"}, idx, int'(out_valid), 0);
    chk({nm, ".dout_r"}, idx, int'(dout_r), 0);
    chk({nm, ".dout_i"}, idx, int'(dout_i), 0);
  endtask

  initial begin
    // Basic block: w=(256,0) for fill/butterfly, then two twiddle cycles.
    blk.push_back(v(1, 0, 256,  0, 256, 0,   0, 0, 0, 0));
    blk.push_back(v(1, 0, 512,  0, 256, 0,   0, 0, 0, 0));
    blk.push_back(v(1, 1, 768,  0, 256, 0,   1, 1, 1024, 0));
    blk.push_back(v(1, 1, 1024, 0, 256, 0,   1, 1, 1536, 0));
    blk.push_back(v(1, 2, 0,    0, 256, 0,   1, 1, -512, 0));
    blk.push_back(v(1, 2, 0,    0, 0,   256, 1, 1, 0, -512));

    // Stall between butterflies, then a back-to-back block seeded by state-2 pushes.
    tv.push_back(v(1, 0, 256,  0, 256, 0,   0, 0, 0, 0));
    tv.push_back(v(1, 0, 512,  0, 256, 0,   0, 0, 0, 0));
    tv.push_back(v(1, 1, 768,  0, 256, 0,   1, 1, 1024, 0));
    for (int k = 0; k < 3; k++)
      tv.push_back(v(0, 1, 999, 77, 256, 0, 0, 1, 1024, 0));
    tv.push_back(v(1, 1, 1024, 0, 256, 0,   1, 1, 1536, 0));
    tv.push_back(v(1, 2, 256,  0, 256, 0,   1, 1, -512, 0));
    tv.push_back(v(1, 2, 512,  0, 0,   256, 1, 1, 0, -512));
    tv.push_back(v(1, 1, 768,  0, 256, 0,   1, 1, 1024, 0));
    tv.push_back(v(1, 1, 1024, 0, 256, 0,   1, 1, 1536, 0));
    tv.push_back(v(1, 2, 0,    0, 256, 0,   1, 1, -512, 0));
    tv.push_back(v(1, 2, 0,    0, 0,   256, 1, 1, 0, -512));
    // Rounding: differences 3 and -3 times 0.5.
    tv.push_back(v(1, 0, 3,  0, 0, 0,   0, 0, 0, 0));
    tv.push_back(v(1, 0, -3, 0, 0, 0,   0, 0, 0, 0));
    tv.push_back(v(1, 1, 0,  0, 0, 0,   1, 1, 3, 0));
    tv.push_back(v(1, 1, 0,  0, 0, 0,   1, 1, -3, 0));
    tv.push_back(v(1, 2, 0,  0, 128, 0, 1, 1, R_POS, 0));
    tv.push_back(v(1, 2, 0,  0, 128, 0, 1, 1, R_NEG, 0));
    // Wrap on the sum, state 3 holds the delay line.
    tv.push_back(v(1, 0, 8388607, 0, 0, 0,   0, 0, 0, 0));
    tv.push_back(v(1, 0, 0,       0, 0, 0,   0, 0, 0, 0));
    tv.push_back(v(1, 1, 1,       0, 0, 0,   1, 1, -8388608, 0));
    tv.push_back(v(1, 1, 0,       0, 0, 0,   1, 1, 0, 0));
    tv.push_back(v(1, 3, 55,      66, 0, 0,  0, 0, 0, 0));
    tv.push_back(v(1, 2, 0,       0, 256, 0, 1, 1, 8388606, 0));
    tv.push_back(v(1, 2, 0,       0, 256, 0, 1, 1, 0, 0));
    // Complex data with nonzero imaginary parts.
    tv.push_back(v(1, 0, 100, 50, 0, 0,     0, 0, 0, 0));
    tv.push_back(v(1, 0, 10,  20, 0, 0,     0, 0, 0, 0));
    tv.push_back(v(1, 1, 0,   0,  0, 0,     1, 1, 100, 50));
    tv.push_back(v(1, 1, 1,   5,  0, 0,     1, 1, 11, 25));
    tv.push_back(v(1, 2, 0,   0,  256, 256, 1, 1, 50, 150));
    tv.push_back(v(1, 2, 0,   0,  0, 256,   1, 1, -15, 9));

    // Reset with random inputs driven.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; state = 2'($urandom_range(0, 3));
      din_r = DW'($urandom); din_i = DW'($urandom);
      w_r = DW'($urandom);   w_i = DW'($urandom);
      @(posedge clk); #1;
      check_zero("reset", k);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    // Delay line must be empty: butterfly against zero, then twiddle the -b differences.
    apply(v(1, 1, 5, 7, 0, 0,   1, 1, 5, 7), "post_rst", 0);
    apply(v(1, 1, 0, 0, 0, 0,   1, 1, 0, 0), "post_rst", 1);
    apply(v(1, 2, 0, 0, 256, 0, 1, 1, -5, -7), "post_rst", 2);
    apply(v(1, 2, 0, 0, 256, 0, 1, 1, 0, 0), "post_rst", 3);

    foreach (blk[k]) apply(blk[k], "block", k);
    foreach (tv[k])  apply(tv[k], "vec", k);

    // Mid-block reset, then the basic block must reproduce exactly.
    apply(v(1, 0, 999, 11, 256, 0, 0, 0, 0, 0), "mid", 0);
    apply(v(1, 0, 777, 22, 256, 0, 0, 0, 0, 0), "mid", 1);
    apply(v(1, 1, 1,   0,  256, 0, 1, 1, 1000, 11), "mid", 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("mid_rst", 0);
    @(posedge clk); #1;
    check_zero("mid_rst", 1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    foreach (blk[k]) apply(blk[k], "block2", k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
